// File: rtl/stage_id_pipe.sv
// rtl/stage_id_pipe.sv - decode stage: register file, load-use detection, ID/EX register
module stage_id_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_WIDTH = 16,
  parameter int LINK_REG   = 31
) (
  input  logic                  Clk_in,
  input  logic                  Rst_n,
  input  logic [31:0]           Instruction_ID,
  input  logic [DATA_WIDTH-1:0] PCAddResult_in_ID,
  input  logic                  Valid_in_ID,
  input  logic [CTRL_WIDTH-1:0] Ctrl_in_ID,
  input  logic [REG_ADDR_W-1:0] DestReg_in_ID,
  input  logic                  MemRead_in_ID,
  input  logic                  UsesRs_in_ID,
  input  logic                  UsesRt_in_ID,
  input  logic                  JAL_in_ID,
  input  logic                  RegWrite_in,
  input  logic [REG_ADDR_W-1:0] WriteRegister_in,
  input  logic [DATA_WIDTH-1:0] WriteData_in,
  input  logic                  Hold_in,
  input  logic                  Flush_in,
  output logic                  Stall_out_ID,
  output logic                  Valid_out_EX,
  output logic [CTRL_WIDTH-1:0] Ctrl_out_EX,
  output logic                  MemRead_out_EX,
  output logic [REG_ADDR_W-1:0] DestReg_out_EX,
  output logic [DATA_WIDTH-1:0] ReadData1_out_EX,
  output logic [DATA_WIDTH-1:0] ReadData2_out_EX,
  output logic [DATA_WIDTH-1:0] SignExt_out_EX,
  output logic [DATA_WIDTH-1:0] PCAddResult_out_EX,
  output logic [REG_ADDR_W-1:0] rs_out_EX,
  output logic [REG_ADDR_W-1:0] rt_out_EX,
  output logic [REG_ADDR_W-1:0] rd_out_EX
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] LINK_IDX = REG_ADDR_W'(LINK_REG);

  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [DATA_WIDTH-1:0] rd1, rd2, sext;
  logic                  wb_en, link_en, load_use;
  logic                  unused_bits;

  assign rs = Instruction_ID[21 +: REG_ADDR_W];
  assign rt = Instruction_ID[16 +: REG_ADDR_W];
  assign rd = Instruction_ID[11 +: REG_ADDR_W];
  assign unused_bits = ^Instruction_ID[31:26];
  assign sext = {{(DATA_WIDTH-16){Instruction_ID[15]}}, Instruction_ID[15:0]};

  assign wb_en = RegWrite_in && (WriteRegister_in != '0);

  // Write-through: a WB write in this cycle is visible to the current read.
  always_comb begin
    rd1 = regs[rs];
    rd2 = regs[rt];
    if (rs == '0)
      rd1 = '0;
    else if (wb_en && (WriteRegister_in == rs))
      rd1 = WriteData_in;
    if (rt == '0)
      rd2 = '0;
    else if (wb_en && (WriteRegister_in == rt))
      rd2 = WriteData_in;
  end

  assign load_use = Valid_out_EX && MemRead_out_EX && (DestReg_out_EX != '0) && Valid_in_ID &&
                    ((UsesRs_in_ID && (rs == DestReg_out_EX)) ||
                     (UsesRt_in_ID && (rt == DestReg_out_EX)));

  assign Stall_out_ID = !Flush_in && (Hold_in || load_use);
  assign link_en      = Valid_in_ID && JAL_in_ID && !Flush_in && !Stall_out_ID;

  // Link write is placed last so it overrides a same-cycle WB to the link register.
  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_en) regs[WriteRegister_in] <= WriteData_in;
      if (link_en) regs[LINK_IDX] <= PCAddResult_in_ID;
    end
  end

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      Valid_out_EX       <= 1'b0;
      Ctrl_out_EX        <= '0;
      MemRead_out_EX     <= 1'b0;
      DestReg_out_EX     <= '0;
      ReadData1_out_EX   <= '0;
      ReadData2_out_EX   <= '0;
      SignExt_out_EX     <= '0;
      PCAddResult_out_EX <= '0;
      rs_out_EX          <= '0;
      rt_out_EX          <= '0;
      rd_out_EX          <= '0;
    end else if (Flush_in || (!Hold_in && load_use)) begin
      Valid_out_EX   <= 1'b0;
      Ctrl_out_EX    <= '0;
      MemRead_out_EX <= 1'b0;
    end else if (!Hold_in) begin
      Valid_out_EX       <= Valid_in_ID;
      Ctrl_out_EX        <= Valid_in_ID ? Ctrl_in_ID : '0;
      MemRead_out_EX     <= Valid_in_ID && MemRead_in_ID;
      DestReg_out_EX     <= DestReg_in_ID;
      ReadData1_out_EX   <= rd1;
      ReadData2_out_EX   <= rd2;
      SignExt_out_EX     <= sext;
      PCAddResult_out_EX <= PCAddResult_in_ID;
      rs_out_EX          <= rs;
      rt_out_EX          <= rt;
      rd_out_EX          <= rd;
    end
  end

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb/tb_stage_id_pipe.sv - scoreboard bench for stage_id_pipe
module tb_stage_id_pipe;

  logic        Clk_in = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] Instruction_ID, PCAddResult_in_ID, WriteData_in;
  logic        Valid_in_ID, MemRead_in_ID, UsesRs_in_ID, UsesRt_in_ID, JAL_in_ID;
  logic [15:0] Ctrl_in_ID;
  logic [4:0]  DestReg_in_ID, WriteRegister_in;
  logic        RegWrite_in, Hold_in, Flush_in;
  logic        Stall_out_ID, Valid_out_EX, MemRead_out_EX;
  logic [15:0] Ctrl_out_EX;
  logic [4:0]  DestReg_out_EX, rs_out_EX, rt_out_EX, rd_out_EX;
  logic [31:0] ReadData1_out_EX, ReadData2_out_EX, SignExt_out_EX, PCAddResult_out_EX;

  stage_id_pipe dut (
    .Clk_in(Clk_in), .Rst_n(Rst_n), .Instruction_ID(Instruction_ID),
    .PCAddResult_in_ID(PCAddResult_in_ID), .Valid_in_ID(Valid_in_ID), .Ctrl_in_ID(Ctrl_in_ID),
    .DestReg_in_ID(DestReg_in_ID), .MemRead_in_ID(MemRead_in_ID), .UsesRs_in_ID(UsesRs_in_ID),
    .UsesRt_in_ID(UsesRt_in_ID), .JAL_in_ID(JAL_in_ID), .RegWrite_in(RegWrite_in),
    .WriteRegister_in(WriteRegister_in), .WriteData_in(WriteData_in), .Hold_in(Hold_in),
    .Flush_in(Flush_in), .Stall_out_ID(Stall_out_ID), .Valid_out_EX(Valid_out_EX),
    .Ctrl_out_EX(Ctrl_out_EX), .MemRead_out_EX(MemRead_out_EX), .DestReg_out_EX(DestReg_out_EX),
    .ReadData1_out_EX(ReadData1_out_EX), .ReadData2_out_EX(ReadData2_out_EX),
    .SignExt_out_EX(SignExt_out_EX), .PCAddResult_out_EX(PCAddResult_out_EX),
    .rs_out_EX(rs_out_EX), .rt_out_EX(rt_out_EX), .rd_out_EX(rd_out_EX)
  );

  always #5 Clk_in = ~Clk_in;

  typedef struct packed {
    logic [15:0] ctrl;
    logic        mr;
    logic [4:0]  dest;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid ID/EX entry must match the oldest expected bundle.
  initial begin : monitor
    exp_t a, e;
    forever begin
      @(negedge Clk_in);
      if (Rst_n && Valid_out_EX) begin
        a = {Ctrl_out_EX, MemRead_out_EX, DestReg_out_EX, ReadData1_out_EX, ReadData2_out_EX,
             SignExt_out_EX, PCAddResult_out_EX, rs_out_EX, rt_out_EX, rd_out_EX};
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_entry: got %h expected none", a);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL idex_bundle: got %h expected %h", a, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] imm, input logic [31:0] pc, input logic [15:0] ctrl,
                        input logic [4:0] dest, input logic mr, input logic urs,
                        input logic urt, input logic jal);
    Valid_in_ID       = v;
    Instruction_ID    = {6'd0, rs, rt, imm};
    PCAddResult_in_ID = pc;
    Ctrl_in_ID        = ctrl;
    DestReg_in_ID     = dest;
    MemRead_in_ID     = mr;
    UsesRs_in_ID      = urs;
    UsesRt_in_ID      = urt;
    JAL_in_ID         = jal;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    RegWrite_in      = en;
    WriteRegister_in = r;
    WriteData_in     = d;
  endtask

  task automatic ctl(input logic hold, input logic flush);
    Hold_in  = hold;
    Flush_in = flush;
  endtask

  // One cycle: push the expected bundle, check stall, then the registered validity.
  task automatic tick(input string name, input logic exp_stall, input logic exp_valid,
                      input logic [31:0] rd1, input logic [31:0] rd2, input logic copy);
    if (exp_valid) begin
      if (!copy)
        last_exp = {Ctrl_in_ID, MemRead_in_ID, DestReg_in_ID, rd1, rd2,
                    {{16{Instruction_ID[15]}}, Instruction_ID[15:0]}, PCAddResult_in_ID,
                    Instruction_ID[25:21], Instruction_ID[20:16], Instruction_ID[15:11]};
      q.push_back(last_exp);
    end
    #1 chk({name, "_stall"}, 64'(Stall_out_ID), 64'(exp_stall));
    @(posedge Clk_in);
    #1 chk({name, "_valid"}, 64'(Valid_out_EX), 64'(exp_valid));
    if (!exp_valid) chk({name, "_ctrl_clear"}, 64'({Ctrl_out_EX, MemRead_out_EX}), 64'd0);
    @(negedge Clk_in);
  endtask

  initial begin : stim
    id_set(0, 0, 0, 16'h0, 32'h0, 16'h0, 5'd0, 0, 0, 0, 0);
    wb(0, 5'd0, 32'h0);
    ctl(0, 0);
    #2;
    chk("rst_valid", 64'(Valid_out_EX), 64'd0);
    chk("rst_outs", 64'({Ctrl_out_EX, ReadData1_out_EX}), 64'd0);
    chk("rst_stall", 64'(Stall_out_ID), 64'd0);
    Hold_in = 1'b1;
    #1 chk("rst_stall_hold", 64'(Stall_out_ID), 64'd1);
    Hold_in = 1'b0;
    @(negedge Clk_in);
    Rst_n = 1'b1;

    wb(1, 5'd5, 32'hCAFE0001);
    id_set(1, 5'd5, 5'd0, 16'h8001, 32'h100, 16'h1234, 5'd3, 0, 1, 0, 0);
    tick("bypass", 0, 1, 32'hCAFE0001, 32'h0, 0);

    wb(1, 5'd0, 32'hDEADBEEF);
    id_set(1, 5'd0, 5'd5, 16'h7FFF, 32'h104, 16'h2222, 5'd4, 0, 1, 1, 0);
    tick("reg0", 0, 1, 32'h0, 32'hCAFE0001, 0);

    wb(0, 5'd0, 32'h0);
    id_set(0, 5'd5, 5'd5, 16'h0, 32'h108, 16'h3333, 5'd6, 1, 1, 1, 0);
    tick("invalid", 0, 0, 32'h0, 32'h0, 0);

    id_set(1, 5'd5, 5'd8, 16'h0020, 32'h10C, 16'h00AA, 5'd8, 1, 1, 0, 0);
    tick("lw8", 0, 1, 32'hCAFE0001, 32'h0, 0);

    id_set(1, 5'd0, 5'd8, 16'h4020, 32'h110, 16'h0055, 5'd9, 0, 1, 1, 0);
    tick("loaduse", 1, 0, 32'h0, 32'h0, 0);
    wb(1, 5'd8, 32'h11112222);
    tick("lu_issue", 0, 1, 32'h0, 32'h11112222, 0);

    wb(1, 5'd31, 32'h5);
    id_set(1, 5'd0, 5'd0, 16'h0, 32'h400010, 16'h0800, 5'd31, 0, 0, 0, 1);
    tick("jal", 0, 1, 32'h0, 32'h0, 0);
    wb(0, 5'd0, 32'h0);
    id_set(1, 5'd31, 5'd31, 16'h0, 32'h114, 16'h0001, 5'd0, 0, 1, 1, 0);
    tick("jal_rd", 0, 1, 32'h400010, 32'h400010, 0);

    wb(1, 5'd31, 32'h5);
    ctl(0, 1);
    id_set(1, 5'd0, 5'd0, 16'h0, 32'h500000, 16'h0800, 5'd31, 0, 0, 0, 1);
    tick("jal_flush", 0, 0, 32'h0, 32'h0, 0);
    wb(0, 5'd0, 32'h0);
    ctl(0, 0);
    id_set(1, 5'd31, 5'd0, 16'h0, 32'h118, 16'h0002, 5'd1, 0, 1, 0, 0);
    tick("r31_wb", 0, 1, 32'h5, 32'h0, 0);

    ctl(1, 0);
    id_set(1, 5'd5, 5'd8, 16'h1234, 32'h11C, 16'h0003, 5'd2, 0, 1, 1, 0);
    repeat (3) tick("hold", 1, 1, 32'h0, 32'h0, 1);
    ctl(0, 0);
    tick("release", 0, 1, 32'hCAFE0001, 32'h11112222, 0);

    id_set(1, 5'd0, 5'd7, 16'h0, 32'h120, 16'h00AB, 5'd7, 1, 1, 0, 0);
    tick("lw7", 0, 1, 32'h0, 32'h0, 0);
    ctl(1, 1);
    id_set(1, 5'd7, 5'd0, 16'h0, 32'h600000, 16'h0800, 5'd31, 0, 1, 0, 1);
    tick("flush_all", 0, 0, 32'h0, 32'h0, 0);
    ctl(0, 0);
    id_set(1, 5'd31, 5'd0, 16'h0, 32'h124, 16'h0004, 5'd1, 0, 1, 0, 0);
    tick("r31_noflink", 0, 1, 32'h5, 32'h0, 0);

    id_set(1, 5'd0, 5'd7, 16'h0, 32'h128, 16'h00AB, 5'd7, 1, 1, 0, 0);
    tick("lw7_b", 0, 1, 32'h0, 32'h0, 0);
    ctl(1, 0);
    id_set(1, 5'd7, 5'd0, 16'h0800, 32'h12C, 16'h0005, 5'd3, 0, 1, 0, 0);
    repeat (2) tick("hold_lu", 1, 1, 32'h0, 32'h0, 1);
    ctl(0, 0);
    tick("lu_after_hold", 1, 0, 32'h0, 32'h0, 0);
    wb(1, 5'd7, 32'h77);
    tick("lu_after_issue", 0, 1, 32'h77, 32'h0, 0);

    wb(0, 5'd0, 32'h0);
    id_set(1, 5'd5, 5'd9, 16'h0, 32'h130, 16'h00AC, 5'd9, 1, 1, 0, 0);
    tick("lw9", 0, 1, 32'hCAFE0001, 32'h0, 0);
    id_set(1, 5'd9, 5'd0, 16'h0, 32'h134, 16'h0006, 5'd4, 0, 1, 0, 0);
    #1 chk("pre_rst_stall", 64'(Stall_out_ID), 64'd1);
    wb(1, 5'd5, 32'hFFFF0000);
    #1 Rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(Valid_out_EX), 64'd0);
    chk("midrst_ctrl", 64'({Ctrl_out_EX, MemRead_out_EX}), 64'd0);
    chk("midrst_rd1", 64'(ReadData1_out_EX), 64'd0);
    chk("midrst_stall", 64'(Stall_out_ID), 64'd0);
    @(posedge Clk_in);
    @(negedge Clk_in);
    Rst_n = 1'b1;
    wb(0, 5'd0, 32'h0);
    id_set(1, 5'd5, 5'd8, 16'h0, 32'h200, 16'h0007, 5'd1, 0, 1, 1, 0);
    tick("post_rst", 0, 1, 32'h0, 32'h0, 0);
    id_set(1, 5'd31, 5'd7, 16'hFFFF, 32'h204, 16'h0008, 5'd2, 0, 1, 1, 0);
    tick("post_rst2", 0, 1, 32'h0, 32'h0, 0);

    id_set(0, 5'd0, 5'd0, 16'h0, 32'h0, 16'h0, 5'd0, 0, 0, 0, 0);
    tick("drain", 0, 0, 32'h0, 32'h0, 0);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_id_pipe.md
# stage_id_pipe

Parametrised decode stage with a registered ID/EX boundary. It holds the architectural register file with two write ports (WB write-back and JAL link write), write-through read bypass, load-use hazard detection and an ID/EX pipeline register with hold, flush and bubble insertion. It sits between the IF/ID register and the execute stage. It consumes the control word produced by the external controller and presents a one-cycle-delayed, validity-tagged bundle to EX.

## Interface
Parameters:
- DATA_WIDTH, 32, register and datapath width
- REG_ADDR_W, 5, register index width; file has 2**REG_ADDR_W entries, entry 0 hardwired zero
- CTRL_WIDTH, 16, width of opaque control word carried to EX
- LINK_REG, 31, register written by JAL

Ports:
- Clk_in  in  1  clock, all state on rising edge
- Rst_n  in  1  asynchronous active-low reset
- Instruction_ID  in  32  instruction in ID; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]
- PCAddResult_in_ID  in  DATA_WIDTH  PC+4 of ID instruction
- Valid_in_ID  in  1  ID instruction is real
- Ctrl_in_ID  in  CTRL_WIDTH  controller output for ID instruction
- DestReg_in_ID  in  REG_ADDR_W  destination register after RegDst selection
- MemRead_in_ID  in  1  ID instruction is a load
- UsesRs_in_ID, UsesRt_in_ID  in  1 each  instruction reads rs / rt
- JAL_in_ID  in  1  ID instruction is JAL
- RegWrite_in  in  1  WB write enable
- WriteRegister_in  in  REG_ADDR_W  WB destination
- WriteData_in  in  DATA_WIDTH  WB data
- Hold_in  in  1  downstream stall; freeze ID/EX
- Flush_in  in  1  kill ID instruction (taken branch/jump resolved later)
- Stall_out_ID  out  1  IF must hold PC and IF/ID this cycle
- Valid_out_EX  out  1  ID/EX entry valid
- Ctrl_out_EX  out  CTRL_WIDTH  registered control word
- MemRead_out_EX  out  1  registered load flag
- DestReg_out_EX  out  REG_ADDR_W  registered destination
- ReadData1_out_EX, ReadData2_out_EX  out  DATA_WIDTH each  registered rs/rt operands
- SignExt_out_EX  out  DATA_WIDTH  registered sign-extended imm
- PCAddResult_out_EX  out  DATA_WIDTH  registered PC+4
- rs_out_EX, rt_out_EX, rd_out_EX  out  REG_ADDR_W each  registered fields

## Operation
- Read: combinational on rs/rt. Index 0 returns 0. If RegWrite_in and WriteRegister_in equals index (nonzero), return WriteData_in (write-through).
- WB write: at clock edge when RegWrite_in and WriteRegister_in≠0.
- Link write: LinkEn = Valid_in_ID & JAL_in_ID & !Flush_in & !Stall_out_ID. Writes PCAddResult_in_ID to LINK_REG. If WB targets the same register in the same cycle, the link value wins.
- Load-use: LoadUse = Valid_out_EX & MemRead_out_EX & DestReg_out_EX≠0 & Valid_in_ID & ((UsesRs & rs==DestReg_out_EX) | (UsesRt & rt==DestReg_out_EX)).
- ID/EX update, priority order:
  1. Flush_in: Valid_out_EX←0, Ctrl/MemRead cleared.
  2. Hold_in: all ID/EX contents unchanged.
  3. LoadUse: bubble; Valid_out_EX←0, Ctrl/MemRead cleared.
  4. Else: load all fields. Valid←Valid_in_ID. When Valid_in_ID=0, Ctrl and MemRead are loaded as 0.
- Stall_out_ID = !Flush_in & (Hold_in | LoadUse).
- Sign extension: imm[15] replicated to DATA_WIDTH.

## Timing
- Latency ID→EX: 1 cycle. Register-file write visible same cycle via bypass, stored next edge.
- Load-use stall: exactly 1 cycle. The next cycle EX holds a bubble, so LoadUse deasserts.
- Reset (async, any time including mid-stall): all registers 0, all ID/EX outputs 0, Valid_out_EX=0. Stall_out_ID then depends only on Hold_in. Writes are suppressed while Rst_n=0.
- Flush and Hold together: flush wins, Stall_out_ID=0.
- Hold and LoadUse together: ID/EX frozen, Stall_out_ID=1. LoadUse is re-evaluated after the hold.

## Test plan
- Bypass: RegWrite_in=1, WriteRegister_in=5, WriteData_in=0xCAFE0001, rs=5 the same cycle → ReadData1_out_EX=0xCAFE0001 next cycle. Write to reg 0 → reads 0.
- Load-use: lw to r8 in EX (valid), ID instruction reads rt=8 → Stall_out_ID=1 for 1 cycle, bubble (Valid_out_EX=0) enters EX, instruction issues the following cycle.
- JAL: PCAddResult_in_ID=0x400010, JAL_in_ID=1, WB writes r31=0x5 the same cycle → r31=0x400010. Repeat with Flush_in=1 → r31=0x5.
- Hold: Hold_in=1 for 3 cycles → ID/EX outputs constant, Stall_out_ID=1. Release → next instruction loads.
- Flush with Hold and LoadUse active → Valid_out_EX=0, Stall_out_ID=0, no link write.
- Rst_n asserted mid-stall → outputs 0 immediately (asynchronous). After release, registers read 0.
